serial_word_rx: RTL and testbench
=================================

// Module: serial_word_rx
// PURPOSE
//   Serial-in word receiver that sits directly upstream of the 16-bit parallel-load holding register.
//   Assembles WIDTH serial bits, plus an optional parity bit, into one parallel word.
//   Presents the word on data_out together with a single-cycle load pulse that drives the register's LOAD input.
//   Bits are sampled only on bit_en strobes, so the bit rate is set externally.
// PARAMETERS
//   WIDTH      16  number of data bits per frame; data_out width
//   MSB_FIRST  1   1: first received bit lands in data_out[WIDTH-1]; 0: first bit lands in data_out[0]
//   PARITY_EN  0   1: one even-parity bit follows the data bits; 0: no parity bit
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous reset, active low
//   start       in   1      synchronous frame-start request, sampled in IDLE only
//   bit_en      in   1      bit strobe; serial_in is valid in cycles where bit_en=1
//   serial_in   in   1      serial data bit
//   data_out    out  WIDTH  last accepted word; connects to the register's DATA input
//   load        out  1      one-cycle pulse, high when data_out has just been updated
//   busy        out  1      high from the cycle after start until the frame completes
//   parity_err  out  1      one-cycle pulse on a parity mismatch (PARITY_EN=1 only)
// BEHAVIOUR
//   Reset: clk single domain; rst asynchronous, active low; all flops clear immediately.
//     state=IDLE; data_out=0; shift register=0; counter=0; load=0; busy=0; parity_err=0.
//   States: IDLE -> SHIFT -> (PARITY if PARITY_EN) -> DONE -> IDLE.
//   IDLE:
//     - busy=0.
//     - start=1 -> SHIFT, counter cleared.
//     - bit_en is ignored in IDLE, including when it coincides with start.
//   SHIFT:
//     - busy=1.
//     - Each bit_en=1 cycle shifts serial_in into the shift register and increments the counter.
//     - MSB_FIRST=1 shifts left, inserting at bit 0. MSB_FIRST=0 shifts right, inserting at bit WIDTH-1.
//     - Cycles without bit_en hold all state.
//     - The bit_en that samples bit WIDTH-1 moves to PARITY (PARITY_EN=1) or DONE (PARITY_EN=0).
//   PARITY:
//     - The next bit_en samples the parity bit p.
//     - ^shift ^ p == 0 -> DONE.
//     - Otherwise parity_err=1 for 1 cycle -> IDLE; data_out unchanged and no load pulse.
//   DONE (one cycle):
//     - data_out <= shift register; load=1 for exactly this cycle; -> IDLE.
//     - busy drops to 0 in the same cycle that load=1.
//   Latency: load is asserted in the cycle after the bit_en that sampled the final bit (data or parity).
//   data_out holds its value between frames. Downstream captures it on the load cycle.
//   Counter: width $clog2(WIDTH); no wrap occurs, because the frame ends at count WIDTH-1.
//   Boundary conditions:
//     - start while busy=1 is ignored; the frame in progress continues.
//     - start in the DONE cycle is ignored. A new frame requires start while in IDLE,
//       so back-to-back frames are separated by at least 1 IDLE cycle.
//     - rst during SHIFT or PARITY aborts the frame: no load pulse, data_out=0.
//     - parity_err and load are never high in the same cycle.
// STRUCTURE
//   Package p2_pkg:
//     - typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} rx_state_t;
//     - localparam WORD_W = 16.
//   Sub-module rx_bit_counter (clear and enable inputs; terminal-count output at WIDTH-1).
//   Top level: FSM, shift register, parity XOR, and the output register for data_out.
// TESTING
//   1 rst low for 3 cycles mid-stream -> all outputs 0; after release, busy=0 and state IDLE.
//   2 MSB_FIRST=1: start, then 16'hA5C3 MSB-first with bit_en every cycle
//     -> load=1 one cycle after bit 16; data_out=16'hA5C3; busy=0 in that cycle.
//   3 MSB_FIRST=0: the same serial bit sequence as test 2 -> data_out=16'hC3A5 bit-reversed (16'hC3A5 reversed = 16'hA5C3 order check).
//   4 bit_en every 3rd cycle, word 16'h0001
//     -> busy held for 46-48 cycles; data_out=16'h0001; exactly one load pulse.
//   5 PARITY_EN=1: word 16'h0003 with p=1
//     -> parity_err pulse; no load; data_out keeps the previous value (16'hA5C3).
//     Then word 16'h0003 with p=0 -> load; data_out=16'h0003.
//   6 Control corner cases, each with the required response:
//     - start pulsed after bit 5 -> frame unaffected.
//     - start together with bit_en in IDLE -> that bit is not sampled.
//     - rst after bit 8 -> no load; the next full frame of 16'hFFFF is received correctly.

Source files
------------

// File: rtl/p2_pkg.sv
// Shared types and constants for the serial word receiver.
package p2_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} rx_state_t;
  localparam int WORD_W = 16;
endpackage

// File: rtl/rx_bit_counter.sv
// Counts accepted bits within a frame; tc flags that the current bit is the last data bit.
module rx_bit_counter #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver with optional even parity, feeding a parallel-load
// holding register through data_out and a one-cycle load strobe.
module serial_word_rx
  import p2_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             load,
  output logic             busy,
  output logic             parity_err,
  output rx_state_t        state
);
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_next;
  logic             cnt_clear;
  logic             cnt_en;
  logic             last_bit;

  // The counter stops at WIDTH-1 so it never wraps; the FSM leaves SHIFT on that bit.
  assign cnt_clear = (state == IDLE) && start;
  assign cnt_en    = (state == SHIFT) && bit_en && !last_bit;

  rx_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (cnt_en),
    .tc    (last_bit)
  );

  always_comb begin
    shift_next = shift;
    if (MSB_FIRST) begin
      shift_next = {shift[WIDTH-2:0], serial_in};
    end else begin
      shift_next = {serial_in, shift[WIDTH-1:1]};
    end
  end

  // Outputs are registered on the transition edge so load/busy line up with the DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift      <= '0;
      data_out   <= '0;
      load       <= 1'b0;
      busy       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      load       <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            shift <= shift_next;
            if (last_bit) begin
              if (PARITY_EN) begin
                state <= PARITY;
              end else begin
                state    <= DONE;
                data_out <= shift_next;
                load     <= 1'b1;
                busy     <= 1'b0;
              end
            end
          end
        end
        PARITY: begin
          if (bit_en) begin
            busy <= 1'b0;
            if ((^shift) ^ serial_in) begin
              parity_err <= 1'b1;
              state      <= IDLE;
            end else begin
              state    <= DONE;
              data_out <= shift;
              load     <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: MSB-first, LSB-first and parity-enabled instances.
module tb_serial_word_rx;
  import p2_pkg::*;

  logic        clk;
  logic        rst;
  logic        start     [3];
  logic        bit_en    [3];
  logic        serial_in [3];
  logic [15:0] data_out  [3];
  logic        load      [3];
  logic        busy      [3];
  logic        perr      [3];
  rx_state_t   st        [3];

  int vectors;
  int miscompares;
  int load_cnt [3];
  int busy_cnt [3];
  int overlap_cnt;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_word_rx #(.WIDTH(16), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .start(start[0]), .bit_en(bit_en[0]), .serial_in(serial_in[0]),
    .data_out(data_out[0]), .load(load[0]), .busy(busy[0]), .parity_err(perr[0]), .state(st[0]));

  serial_word_rx #(.WIDTH(16), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .start(start[1]), .bit_en(bit_en[1]), .serial_in(serial_in[1]),
    .data_out(data_out[1]), .load(load[1]), .busy(busy[1]), .parity_err(perr[1]), .state(st[1]));

  serial_word_rx #(.WIDTH(16), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_par (
    .clk(clk), .rst(rst), .start(start[2]), .bit_en(bit_en[2]), .serial_in(serial_in[2]),
    .data_out(data_out[2]), .load(load[2]), .busy(busy[2]), .parity_err(perr[2]), .state(st[2]));

  // Pulse monitors sample on the falling edge, away from the active edge.
  initial begin
    for (int i = 0; i < 3; i++) begin
      load_cnt[i] = 0;
      busy_cnt[i] = 0;
    end
    overlap_cnt = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (load[i] === 1'b1) load_cnt[i]++;
      if (busy[i] === 1'b1) busy_cnt[i]++;
      if (load[i] === 1'b1 && perr[i] === 1'b1) overlap_cnt++;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int d, input logic b, input int gap);
    bit_en[d] = 1'b0;
    for (int g = 0; g < gap; g++) step();
    bit_en[d]    = 1'b1;
    serial_in[d] = b;
    step();
    bit_en[d]    = 1'b0;
    serial_in[d] = 1'b0;
  endtask

  task automatic send_bits(input int d, input logic [15:0] word, input int gap);
    for (int i = 15; i >= 0; i--) send_bit(d, word[i], gap);
  endtask

  // Returns in the cycle right after the final sampled bit (the load cycle).
  task automatic send_frame(input int d, input logic [15:0] word, input int gap,
                            input bit with_par, input logic p);
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
    send_bits(d, word, gap);
    if (with_par) send_bit(d, p, gap);
  endtask

  task automatic test_reset();
    int base;
    rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (data_out[i] !== 16'h0000 || load[i] !== 1'b0 || busy[i] !== 1'b0 ||
          perr[i] !== 1'b0 || st[i] !== IDLE) begin
        miscompares++;
        $display("FAIL reset_init dut%0d: got data=%h load=%b busy=%b perr=%b state=%0d, expected all zero/IDLE",
                 i, data_out[i], load[i], busy[i], perr[i], st[i]);
      end
    end
    rst = 1'b1;
    step();
    base = load_cnt[0];
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(0, i[0], 0);
    rst = 1'b0;
    #1;
    vectors++;
    if (busy[0] !== 1'b0 || st[0] !== IDLE || data_out[0] !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_async: got busy=%b state=%0d data=%h, expected 0/IDLE/0000", busy[0], st[0], data_out[0]);
    end
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    vectors++;
    if (busy[0] !== 1'b0 || st[0] !== IDLE || load[0] !== 1'b0 || load_cnt[0] !== base) begin
      miscompares++;
      $display("FAIL reset_release: got busy=%b state=%0d load=%b loads=%0d, expected 0/IDLE/0/%0d",
               busy[0], st[0], load[0], load_cnt[0], base);
    end
  endtask

  task automatic test_msb_first();
    int base;
    base = load_cnt[0];
    send_frame(0, 16'hA5C3, 0, 1'b0, 1'b0);
    vectors++;
    if (load[0] !== 1'b1 || data_out[0] !== 16'hA5C3 || busy[0] !== 1'b0 || st[0] !== DONE) begin
      miscompares++;
      $display("FAIL msb_first: got load=%b data=%h busy=%b state=%0d, expected 1/a5c3/0/DONE",
               load[0], data_out[0], busy[0], st[0]);
    end
    step();
    vectors++;
    if (load[0] !== 1'b0 || st[0] !== IDLE || load_cnt[0] !== base + 1 || data_out[0] !== 16'hA5C3) begin
      miscompares++;
      $display("FAIL msb_after: got load=%b state=%0d loads=%0d data=%h, expected 0/IDLE/%0d/a5c3",
               load[0], st[0], load_cnt[0], data_out[0], base + 1);
    end
  endtask

  task automatic test_lsb_first();
    send_frame(1, 16'hA5C3, 0, 1'b0, 1'b0);
    vectors++;
    if (load[1] !== 1'b1 || data_out[1] !== 16'hC3A5 || busy[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL lsb_first: got load=%b data=%h busy=%b, expected 1/c3a5/0", load[1], data_out[1], busy[1]);
    end
    step();
  endtask

  task automatic test_slow_strobe();
    int lbase;
    int bbase;
    lbase = load_cnt[0];
    bbase = busy_cnt[0];
    send_frame(0, 16'h0001, 2, 1'b0, 1'b0);
    vectors++;
    if (data_out[0] !== 16'h0001 || load[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL slow_data: got data=%h load=%b, expected 0001/1", data_out[0], load[0]);
    end
    step();
    step();
    vectors++;
    if (busy_cnt[0] - bbase < 46 || busy_cnt[0] - bbase > 48 || load_cnt[0] !== lbase + 1) begin
      miscompares++;
      $display("FAIL slow_busy: got busy_cycles=%0d loads=%0d, expected 46..48 and 1",
               busy_cnt[0] - bbase, load_cnt[0] - lbase);
    end
  endtask

  task automatic test_parity();
    int base;
    send_frame(2, 16'hA5C3, 0, 1'b1, 1'b0);
    vectors++;
    if (load[2] !== 1'b1 || data_out[2] !== 16'hA5C3 || perr[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL par_good_first: got load=%b data=%h perr=%b, expected 1/a5c3/0", load[2], data_out[2], perr[2]);
    end
    step();
    step();
    base = load_cnt[2];
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    send_bits(2, 16'h0003, 0);
    vectors++;
    if (st[2] !== PARITY || load[2] !== 1'b0 || busy[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL par_wait: got state=%0d load=%b busy=%b, expected PARITY/0/1", st[2], load[2], busy[2]);
    end
    send_bit(2, 1'b1, 0);
    vectors++;
    if (perr[2] !== 1'b1 || load[2] !== 1'b0 || data_out[2] !== 16'hA5C3 || st[2] !== IDLE) begin
      miscompares++;
      $display("FAIL par_err: got perr=%b load=%b data=%h state=%0d, expected 1/0/a5c3/IDLE",
               perr[2], load[2], data_out[2], st[2]);
    end
    step();
    vectors++;
    if (perr[2] !== 1'b0 || load_cnt[2] !== base) begin
      miscompares++;
      $display("FAIL par_err_pulse: got perr=%b loads=%0d, expected 0/%0d", perr[2], load_cnt[2], base);
    end
    send_frame(2, 16'h0003, 0, 1'b1, 1'b0);
    vectors++;
    if (load[2] !== 1'b1 || data_out[2] !== 16'h0003 || perr[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL par_good: got load=%b data=%h perr=%b, expected 1/0003/0", load[2], data_out[2], perr[2]);
    end
    step();
  endtask

  task automatic test_start_mid_frame();
    logic [15:0] w;
    w = 16'h1234;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int i = 15; i >= 11; i--) send_bit(0, w[i], 0);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int i = 10; i >= 0; i--) send_bit(0, w[i], 0);
    vectors++;
    if (load[0] !== 1'b1 || data_out[0] !== 16'h1234) begin
      miscompares++;
      $display("FAIL start_mid_frame: got load=%b data=%h, expected 1/1234", load[0], data_out[0]);
    end
    step();
  endtask

  task automatic test_start_with_bit_en();
    start[0]     = 1'b1;
    bit_en[0]    = 1'b1;
    serial_in[0] = 1'b1;
    step();
    start[0]     = 1'b0;
    bit_en[0]    = 1'b0;
    serial_in[0] = 1'b0;
    send_bits(0, 16'h3C5A, 0);
    vectors++;
    if (load[0] !== 1'b1 || data_out[0] !== 16'h3C5A) begin
      miscompares++;
      $display("FAIL start_bit_en: got load=%b data=%h, expected 1/3c5a", load[0], data_out[0]);
    end
    step();
  endtask

  task automatic test_reset_abort();
    int base;
    base = load_cnt[0];
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(0, 1'b1, 0);
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    vectors++;
    if (load_cnt[0] !== base || data_out[0] !== 16'h0000 || busy[0] !== 1'b0 || st[0] !== IDLE) begin
      miscompares++;
      $display("FAIL rst_abort: got loads=%0d data=%h busy=%b state=%0d, expected %0d/0000/0/IDLE",
               load_cnt[0], data_out[0], busy[0], st[0], base);
    end
    send_frame(0, 16'hFFFF, 0, 1'b0, 1'b0);
    vectors++;
    if (load[0] !== 1'b1 || data_out[0] !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL rst_next_frame: got load=%b data=%h, expected 1/ffff", load[0], data_out[0]);
    end
    step();
  endtask

  task automatic test_back_to_back();
    send_frame(0, 16'h8001, 0, 1'b0, 1'b0);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    vectors++;
    if (st[0] !== IDLE || busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_done: got state=%0d busy=%b, expected IDLE/0", st[0], busy[0]);
    end
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    vectors++;
    if (st[0] !== SHIFT || busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL start_in_idle: got state=%0d busy=%b, expected SHIFT/1", st[0], busy[0]);
    end
    send_bits(0, 16'h7E18, 0);
    vectors++;
    if (load[0] !== 1'b1 || data_out[0] !== 16'h7E18) begin
      miscompares++;
      $display("FAIL back_to_back: got load=%b data=%h, expected 1/7e18", load[0], data_out[0]);
    end
    step();
    vectors++;
    if (overlap_cnt !== 0) begin
      miscompares++;
      $display("FAIL load_perr_overlap: got %0d overlapping cycles, expected 0", overlap_cnt);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i]     = 1'b0;
      bit_en[i]    = 1'b0;
      serial_in[i] = 1'b0;
    end
    #2;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_slow_strobe();
    test_parity();
    test_start_mid_frame();
    test_start_with_bit_en();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
